// File: rtl/iob_clint_pkg.sv
// rtl/iob_clint_pkg.sv - shared constants and helpers for the iob_clint core-local interruptor
//
// Purpose: default widths, register address map and reset constants, plus the
// byte-strobe merge helper used for every 32-bit register half.
// Ports: none (package).

package iob_clint_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 32;
    localparam int N_CORES_DEF = 1;

    // Byte offsets of the register banks.
    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_BASE    = 16'hBFF8;

    // Compare value that can never be reached by a freshly reset mtime.
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace only the strobed bytes of a 32-bit word.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/iob_clint_if.sv
// rtl/iob_clint_if.sv - IOb native bus bundle for the iob_clint register port
//
// Purpose: groups the IOb request/response signals.
// Signals: iob_avalid, iob_addr, iob_wdata, iob_wstrb (master -> slave);
//          iob_rvalid, iob_rdata, iob_ready (slave -> master).

interface iob_clint_if
    import iob_clint_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic                  iob_avalid;
    logic [ADDR_W-1:0]     iob_addr;
    logic [DATA_W-1:0]     iob_wdata;
    logic [DATA_W/8-1:0]   iob_wstrb;
    logic                  iob_rvalid;
    logic [DATA_W-1:0]     iob_rdata;
    logic                  iob_ready;

    modport master (
        output iob_avalid, iob_addr, iob_wdata, iob_wstrb,
        input  iob_rvalid, iob_rdata, iob_ready
    );

    modport slave (
        input  iob_avalid, iob_addr, iob_wdata, iob_wstrb,
        output iob_rvalid, iob_rdata, iob_ready
    );

endinterface

// File: rtl/iob_clint_rtc_tick.sv
// rtl/iob_clint_rtc_tick.sv - rtc synchronizer and rising-edge detector
//
// Purpose: brings the slow asynchronous rtc into the clk_i domain and emits a
// single-cycle tick per rtc rising edge.
// Ports: clk_i, arst_n_i (async active-low), rtc (async input), tick (one clk_i cycle).

module iob_clint_rtc_tick (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic rtc,
    output logic tick
);

    logic [1:0] sync;
    logic       prev;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync <= 2'b00;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], rtc};
            prev <= sync[1];
        end
    end

    // Tick is high in the single cycle where the synchronized level has just risen.
    assign tick = sync[1] & ~prev;

endmodule

// File: rtl/iob_clint.sv
// rtl/iob_clint.sv - RISC-V core-local interruptor on the IOb native bus
//
// Purpose: 64-bit mtime advanced by rtc ticks, per-core mtimecmp driving mtip,
// per-core software interrupt bits driving msip.
// Ports: clk_i, arst_n_i (async active-low), rtc (async real-time clock),
//        iob (IOb slave bundle), mtip[N_CORES-1:0], msip[N_CORES-1:0].
// Register halves are 32 bits wide, so DATA_W is expected to be 32.

module iob_clint
    import iob_clint_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int N_CORES = N_CORES_DEF
) (
    input  logic               clk_i,
    input  logic               arst_n_i,
    input  logic               rtc,
    iob_clint_if.slave         iob,
    output logic [N_CORES-1:0] mtip,
    output logic [N_CORES-1:0] msip
);

    logic              tick;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] waddr;

    logic              hit_time_lo;
    logic              hit_time_hi;
    logic [N_CORES-1:0] hit_msip;
    logic [N_CORES-1:0] hit_cmp_lo;
    logic [N_CORES-1:0] hit_cmp_hi;

    logic [63:0]       mtime;
    logic [63:0]       mtime_inc;
    logic [63:0]       mtime_nxt;
    logic [63:0]       mtimecmp [N_CORES];

    logic [DATA_W-1:0] rd_word;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    iob_clint_rtc_tick u_rtc_tick (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .rtc      (rtc),
        .tick     (tick)
    );

    assign iob.iob_ready  = 1'b1;
    assign iob.iob_rvalid = rvalid_q;
    assign iob.iob_rdata  = rdata_q;

    assign wr = iob.iob_avalid & (|iob.iob_wstrb);
    assign rd = iob.iob_avalid & ~(|iob.iob_wstrb);

    // Byte lanes within a word are ignored for decode.
    assign waddr = iob.iob_addr & ~ADDR_W'(3);

    always_comb begin
        hit_time_lo = (waddr == ADDR_W'(MTIME_BASE));
        hit_time_hi = (waddr == ADDR_W'(MTIME_BASE) + ADDR_W'(4));
        hit_msip    = '0;
        hit_cmp_lo  = '0;
        hit_cmp_hi  = '0;
        for (int h = 0; h < N_CORES; h++) begin
            hit_msip[h]   = (waddr == ADDR_W'(MSIP_BASE) + ADDR_W'(4 * h));
            hit_cmp_lo[h] = (waddr == ADDR_W'(MTIMECMP_BASE) + ADDR_W'(8 * h));
            hit_cmp_hi[h] = (waddr == ADDR_W'(MTIMECMP_BASE) + ADDR_W'(8 * h + 4));
        end
    end

    // A bus write to one mtime half overrides that half only; the other half
    // keeps the ticked value, so the carry comes from the pre-write mtime.
    assign mtime_inc = mtime + 64'(tick);

    always_comb begin
        mtime_nxt = mtime_inc;
        if (wr && hit_time_lo) begin
            mtime_nxt[31:0] = strb_merge(mtime[31:0], iob.iob_wdata, iob.iob_wstrb);
        end
        if (wr && hit_time_hi) begin
            mtime_nxt[63:32] = strb_merge(mtime[63:32], iob.iob_wdata, iob.iob_wstrb);
        end
    end

    always_comb begin
        rd_word = '0;
        if (hit_time_lo) begin
            rd_word = mtime[31:0];
        end
        if (hit_time_hi) begin
            rd_word = mtime[63:32];
        end
        for (int h = 0; h < N_CORES; h++) begin
            if (hit_msip[h]) begin
                rd_word = {{(DATA_W-1){1'b0}}, msip[h]};
            end
            if (hit_cmp_lo[h]) begin
                rd_word = mtimecmp[h][31:0];
            end
            if (hit_cmp_hi[h]) begin
                rd_word = mtimecmp[h][63:32];
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            mtime    <= '0;
            msip     <= '0;
            mtip     <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            for (int h = 0; h < N_CORES; h++) begin
                mtimecmp[h] <= MTIMECMP_RST;
            end
        end else begin
            mtime    <= mtime_nxt;
            rvalid_q <= rd;
            if (rd) begin
                rdata_q <= rd_word;
            end
            for (int h = 0; h < N_CORES; h++) begin
                if (wr && hit_cmp_lo[h]) begin
                    mtimecmp[h][31:0] <= strb_merge(mtimecmp[h][31:0], iob.iob_wdata, iob.iob_wstrb);
                end
                if (wr && hit_cmp_hi[h]) begin
                    mtimecmp[h][63:32] <= strb_merge(mtimecmp[h][63:32], iob.iob_wdata, iob.iob_wstrb);
                end
                if (wr && hit_msip[h] && iob.iob_wstrb[0]) begin
                    msip[h] <= iob.iob_wdata[0];
                end
                // Compares the current registered values, so mtip trails a
                // register change by one cycle.
                mtip[h] <= (mtime >= mtimecmp[h]);
            end
        end
    end

endmodule

// File: tb/tb_iob_clint.sv
// tb/tb_iob_clint.sv - directed self-checking bench for iob_clint

module tb_iob_clint;

    logic       clk;
    logic       rst_n;
    logic       rtc;
    logic [0:0] mtip;
    logic [0:0] msip;

    int n_pass;
    int n_total;

    iob_clint_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    iob_clint #(.ADDR_W(16), .DATA_W(32), .N_CORES(1)) dut (
        .clk_i    (clk),
        .arst_n_i (rst_n),
        .rtc      (rtc),
        .iob      (bus.slave),
        .mtip     (mtip),
        .msip     (msip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        bus.iob_avalid = 1'b1;
        bus.iob_addr   = a;
        bus.iob_wdata  = d;
        bus.iob_wstrb  = s;
        @(negedge clk);
        bus.iob_avalid = 1'b0;
        bus.iob_wstrb  = 4'h0;
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
        logic        rv1;
        logic        rv2;
        logic [31:0] d;
        @(negedge clk);
        bus.iob_avalid = 1'b1;
        bus.iob_addr   = a;
        bus.iob_wstrb  = 4'h0;
        @(negedge clk);
        bus.iob_avalid = 1'b0;
        rv1 = bus.iob_rvalid;
        d   = bus.iob_rdata;
        @(negedge clk);
        rv2 = bus.iob_rvalid;
        check({tag, "_rvalid"}, 64'(rv1), 64'd1);
        check({tag, "_rvalid_drop"}, 64'(rv2), 64'd0);
        check(tag, 64'(d), 64'(exp));
    endtask

    // Each edge: 3 cycles high, 3 low; the tick and mtip update settle inside.
    task automatic rtc_edges(input int n);
        for (int i = 0; i < n; i++) begin
            rtc = 1'b1;
            repeat (3) @(negedge clk);
            rtc = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        rtc     = 1'b0;
        bus.iob_avalid = 1'b0;
        bus.iob_addr   = '0;
        bus.iob_wdata  = '0;
        bus.iob_wstrb  = '0;

        // Reset
        repeat (100) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mtip", 64'(mtip), 64'd0);
        check("rst_msip", 64'(msip), 64'd0);
        check("rst_rvalid", 64'(bus.iob_rvalid), 64'd0);
        check("rst_ready", 64'(bus.iob_ready), 64'd1);
        read_check("rst_mtime_lo", 16'hBFF8, 32'h0);
        read_check("rst_cmp_lo", 16'h4000, 32'hFFFF_FFFF);

        // Byte strobes on mtimecmp
        bus_write(16'h4000, 32'hAABB_CCDD, 4'b0001);
        read_check("strb_cmp_lo", 16'h4000, 32'hFFFF_FFDD);
        bus_write(16'h4004, 32'h1122_3344, 4'b0110);
        read_check("strb_cmp_hi", 16'h4004, 32'hFF22_33FF);

        // Timer interrupt at the 200th rtc edge
        bus_write(16'h4000, 32'd200, 4'hF);
        bus_write(16'h4004, 32'd0, 4'hF);
        rtc_edges(199);
        check("timer_mtip_before", 64'(mtip), 64'd0);
        rtc = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mtip[0] === 1'b1 && lat == 0) lat = i;
        end
        rtc = 1'b0;
        repeat (3) @(negedge clk);
        check("timer_mtip_seen", 64'(lat != 0), 64'd1);
        check("timer_mtip_latency_le4", 64'(lat <= 4), 64'd1);
        read_check("timer_mtime_lo", 16'hBFF8, 32'd200);
        read_check("timer_mtime_hi", 16'hBFFC, 32'd0);

        // Clear by rewriting mtime, then re-arm
        bus_write(16'hBFF8, 32'd0, 4'hF);
        @(negedge clk);
        check("clear_mtip", 64'(mtip), 64'd0);
        bus_write(16'h4000, 32'd100, 4'hF);
        rtc_edges(99);
        check("rearm_mtip_before", 64'(mtip), 64'd0);
        rtc_edges(1);
        check("rearm_mtip_after", 64'(mtip), 64'd1);

        // Software interrupt
        bus_write(16'h0000, 32'd1, 4'hF);
        check("msip_set", 64'(msip), 64'd1);
        read_check("msip_read1", 16'h0000, 32'd1);
        bus_write(16'h0000, 32'hFFFF_FFFE, 4'hF);
        check("msip_clr", 64'(msip), 64'd0);
        read_check("msip_read0", 16'h0000, 32'd0);

        // Carry from low to high mtime word
        bus_write(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        rtc_edges(1);
        read_check("carry_lo", 16'hBFF8, 32'd0);
        read_check("carry_hi", 16'hBFFC, 32'd1);

        // Bus write to mtime high word collides with a tick: write wins there,
        // low word still increments.
        bus_write(16'hBFFC, 32'd5, 4'hF);
        bus_write(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        rtc = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.iob_avalid = 1'b1;
        bus.iob_addr   = 16'hBFFC;
        bus.iob_wdata  = 32'h77;
        bus.iob_wstrb  = 4'hF;
        @(negedge clk);
        bus.iob_avalid = 1'b0;
        bus.iob_wstrb  = 4'h0;
        repeat (2) @(negedge clk);
        rtc = 1'b0;
        repeat (3) @(negedge clk);
        read_check("collide_lo", 16'hBFF8, 32'd0);
        read_check("collide_hi", 16'hBFFC, 32'h77);

        // Unmapped accesses
        bus_write(16'h2000, 32'hDEAD_BEEF, 4'hF);
        check("unmapped_wr_no_rvalid", 64'(bus.iob_rvalid), 64'd0);
        read_check("unmapped_2000", 16'h2000, 32'd0);
        read_check("unmapped_0004", 16'h0004, 32'd0);

        // Write then read in the very next cycle
        @(negedge clk);
        bus.iob_avalid = 1'b1;
        bus.iob_addr   = 16'h4000;
        bus.iob_wdata  = 32'h1234_5678;
        bus.iob_wstrb  = 4'hF;
        @(negedge clk);
        bus.iob_wstrb  = 4'h0;
        @(negedge clk);
        bus.iob_avalid = 1'b0;
        check("b2b_rvalid", 64'(bus.iob_rvalid), 64'd1);
        check("b2b_rdata", 64'(bus.iob_rdata), 64'h1234_5678);

        // Reset mid-operation drops a pending rvalid and restores state
        bus_write(16'h0000, 32'd1, 4'hF);
        @(negedge clk);
        bus.iob_avalid = 1'b1;
        bus.iob_addr   = 16'hBFF8;
        bus.iob_wstrb  = 4'h0;
        @(negedge clk);
        bus.iob_avalid = 1'b0;
        check("midrst_pending_rvalid", 64'(bus.iob_rvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_rvalid", 64'(bus.iob_rvalid), 64'd0);
        check("midrst_msip", 64'(msip), 64'd0);
        check("midrst_mtip", 64'(mtip), 64'd0);
        repeat (100) @(negedge clk);
        rst_n = 1'b1;
        read_check("midrst_cmp_lo", 16'h4000, 32'hFFFF_FFFF);
        read_check("midrst_cmp_hi", 16'h4004, 32'hFFFF_FFFF);
        read_check("midrst_mtime_hi", 16'hBFFC, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
